hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard/interlock block for the 5-stage ARM core.
- Sits beside the controller and datapath, consuming register addresses plus the controller's stage signals: RegWriteM/W, MemtoRegE, PCSrcW, PCWrPendingF, BranchTakenD and MulOpE.
- Produces operand-forwarding selects, stage stalls and flushes; FlushE feeds the controller's E-stage clear.
- Adds a multi-cycle multiply interlock: MUL/MLA occupies Execute for MUL_CYCLES cycles.

Parameters:
MUL_CYCLES, 3, cycles a multiply occupies Execute (legal 1..15; 1 = no interlock)
CNT_W, 4, width of multiply cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
RA1D, RA2D  in  4 each  source register addresses in Decode
RA1E, RA2E  in  4 each  source register addresses in Execute
WA3E, WA3M, WA3W  in  4 each  destination register address per stage
RegWriteE, RegWriteM, RegWriteW  in  1 each  register write enable per stage (M/W already condition-gated)
MemtoRegE  in  1  Execute instruction is a load
PCWrPendingF  in  1  PC write in flight in D/E/M
PCSrcW  in  1  PC write retiring in Writeback
BranchTakenD  in  1  early-resolved taken branch in Decode
MulOpE  in  1  Execute instruction is MUL/MLA
ForwardAE, ForwardBE  out  2 each  operand select: 00 regfile, 01 ResultW, 10 ALUOutM
StallF, StallD, StallE  out  1 each  hold F/D/E pipeline registers
FlushD, FlushE, FlushM  out  1 each  clear D/E/M pipeline registers (bubble)
MulBusyE  out  1  multiply interlock active (state BUSY)

Behaviour:
- Forwarding (combinational): ForwardAE = 10 if RegWriteM & RA1E==WA3M & RA1E!=15; else 01 if RegWriteW & RA1E==WA3W & RA1E!=15; else 00. M has priority over W. ForwardBE is identical using RA2E. R15 is never forwarded.
- Load-use: LDRstall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
- Multiply FSM, states IDLE/BUSY, 4-bit counter cnt:
  - IDLE: if MulOpE & MUL_CYCLES>1 & ~PCSrcW, then mulstall=1, next BUSY, cnt<=MUL_CYCLES-2.
  - BUSY: mulstall = (cnt!=0); cnt decrements; when cnt==0, next IDLE and mulstall=0, so the multiply leaves E on that edge.
  - Total stall cycles = MUL_CYCLES-1; the multiply occupies E for MUL_CYCLES cycles.
  - PCSrcW in any state (younger multiply must die): next IDLE, cnt<=0, mulstall=0.
- Stall outputs:
  - StallE = mulstall.
  - StallD = LDRstall | mulstall.
  - StallF = LDRstall | mulstall | PCWrPendingF.
- Flush outputs:
  - FlushM = mulstall (bubble into M while E is held).
  - FlushD = PCWrPendingF | PCSrcW | (BranchTakenD & ~StallD).
  - FlushE = PCSrcW | ((LDRstall | BranchTakenD) & ~mulstall).
  - A clear overrides a stall in the same register (floprc semantics).
- Simultaneous events:
  - Branch in D while a multiply stalls E: no D/E flush until the stall releases; the branch then flushes normally.
  - PCSrcW during BUSY: FlushE=1, StallE=0, FSM aborts to IDLE.
- Reset, asynchronous: state IDLE, cnt 0. Outputs while reset is asserted: all stalls 0, FlushM 0, MulBusyE 0. Forward/flush outputs follow the combinational equations with mulstall=0.
- After reset is released mid-multiply, the next MulOpE restarts a full interlock.
- Latency: all outputs are combinational from inputs and state; state updates on the rising clk edge.

Decomposition:
- Shared package/header hazard_defs:
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - FSM state encodings S_IDLE=1'b0, S_BUSY=1'b1
  - PC_REG=4'd15
- One sub-module, mul_interlock: FSM plus counter. Inputs clk, reset, MulOpE, Kill(=PCSrcW). Outputs mulstall, MulBusyE.
- Forwarding and stall/flush equations stay in hazard_unit.

Test Plan:
- ADD R1 in M (RegWriteM=1, WA3M=1), R1 in W (WA3W=1), RA1E=1 -> ForwardAE=10. Drop RegWriteM -> 01. RA1E=15 -> 00.
- LDR R2 in E (MemtoRegE=1, RegWriteE=1, WA3E=2), RA2D=2 -> StallF=StallD=FlushE=1 for exactly one cycle, FlushD=0.
- MUL_CYCLES=3, MulOpE held while stalled -> StallE=StallD=StallF=FlushM=1 for 2 cycles, MulBusyE=1 on the 2nd and 3rd cycles, all 0 on cycle 3.
- MulOpE with BranchTakenD=1 in D -> FlushD=FlushE=0 during the 2 stall cycles; FlushD=FlushE=1 on the release cycle.
- PCSrcW=1 in the 2nd multiply cycle (BUSY, cnt=1) -> FlushE=1, StallE=0, FlushD=1; next cycle MulBusyE=0 and the FSM is IDLE.
- Assert reset asynchronously mid-BUSY (no clk edge) -> MulBusyE and StallE drop to 0 immediately. After release, MulOpE yields a fresh 2-cycle stall.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// ============================================================================
//  Package     : hazard_defs
//  Description : Shared constants and helpers for the 5-stage ARM hazard unit.
//                Holds the operand-forwarding select encodings, the multiply
//                interlock FSM state encodings, the PC register index and a
//                forwarding-select helper function.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_defs;

  // Operand-forwarding select encodings driven on ForwardAE/ForwardBE
  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from ALUOutM

  // Multiply interlock FSM states
  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  // R15 reads return PC+8 from the regfile path, so it is never forwarded
  localparam logic [3:0] PC_REG = 4'd15;

  // Forwarding select for one Execute source operand. Memory wins over
  // Writeback because it holds the younger producer.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       wr_m,
    input logic [3:0] wa_m,
    input logic       wr_w,
    input logic [3:0] wa_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ra != PC_REG) begin
      if (wr_m && (ra == wa_m)) begin
        sel = FWD_M;
      end else if (wr_w && (ra == wa_w)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_unit_mul_interlock.sv
// ============================================================================
//  Module      : mul_interlock
//  Description : Multi-cycle multiply interlock. Holds a MUL/MLA in Execute
//                for MUL_CYCLES cycles by raising mulstall for MUL_CYCLES-1
//                cycles. A retiring PC write (Kill) aborts the interlock.
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous active-high reset
//                MulOpE    - Execute holds a MUL/MLA
//                Kill      - PC write retiring in Writeback (aborts)
//                mulstall  - hold Execute / insert bubble into Memory
//                MulBusyE  - FSM is in BUSY
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_interlock
  import hazard_defs::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MulOpE,
  input  logic Kill,
  output logic mulstall,
  output logic MulBusyE
);

  // With a single-cycle multiply there is nothing to interlock
  localparam bit MUL_EN = (MUL_CYCLES > 1);
  // First IDLE cycle stalls, then BUSY counts down from MUL_CYCLES-2 to 0
  localparam logic [CNT_W-1:0] CNT_INIT =
    (MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 2) : '0;

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_w = 1'b0;
    if (Kill) begin
      // The multiply is younger than the retiring PC write and must die
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (MulOpE && MUL_EN) begin
        stall_w = 1'b1;
        state_d = S_BUSY;
        cnt_d   = CNT_INIT;
      end
    end else begin
      if (cnt_q == '0) begin
        // Release: multiply leaves Execute on this edge
        state_d = S_IDLE;
      end else begin
        stall_w = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // State is already IDLE under reset, but a MulOpE seen in IDLE would still
  // raise the stall combinationally, so gate it explicitly.
  assign mulstall = stall_w & ~reset;
  assign MulBusyE = (state_q == S_BUSY);

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline hazard/interlock unit for the 5-stage ARM core.
//                Produces operand-forwarding selects, stage stalls and
//                flushes, including a multi-cycle multiply interlock.
//  Ports       : clk, reset                 - clock / async active-high reset
//                RA1D, RA2D                 - Decode source registers
//                RA1E, RA2E                 - Execute source registers
//                WA3E, WA3M, WA3W           - destination register per stage
//                RegWriteE/M/W              - register write enable per stage
//                MemtoRegE                  - Execute holds a load
//                PCWrPendingF               - PC write in flight in D/E/M
//                PCSrcW                     - PC write retiring in Writeback
//                BranchTakenD               - taken branch resolved in Decode
//                MulOpE                     - Execute holds MUL/MLA
//                ForwardAE, ForwardBE       - operand forwarding selects
//                StallF, StallD, StallE     - hold pipeline registers
//                FlushD, FlushE, FlushM     - clear pipeline registers
//                MulBusyE                   - multiply interlock in BUSY
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import hazard_defs::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCWrPendingF,
  input  logic       PCSrcW,
  input  logic       BranchTakenD,
  input  logic       MulOpE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulBusyE
);

  logic w_ldrstall;
  logic w_mulstall;

  mul_interlock #(
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mul_interlock (
    .clk      (clk),
    .reset    (reset),
    .MulOpE   (MulOpE),
    .Kill     (PCSrcW),
    .mulstall (w_mulstall),
    .MulBusyE (MulBusyE)
  );

  assign ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
  assign ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

  // Load result is not available until Memory; a dependent in Decode waits
  assign w_ldrstall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));

  // All stalls are forced low while reset is held
  assign StallE = w_mulstall;
  assign StallD = (w_ldrstall | w_mulstall) & ~reset;
  assign StallF = (w_ldrstall | w_mulstall | PCWrPendingF) & ~reset;

  // While Execute is held by a multiply, Memory receives bubbles
  assign FlushM = w_mulstall;
  // A branch in Decode is deferred while Decode is stalled
  assign FlushD = PCWrPendingF | PCSrcW | (BranchTakenD & ~StallD);
  // Execute cannot take a bubble while the multiply occupies it, except
  // when a retiring PC write kills the multiply
  assign FlushE = PCSrcW | ((w_ldrstall | BranchTakenD) & ~w_mulstall);

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Self-checking bench for hazard_unit (MUL_CYCLES = 3).
//                Table of combinational vectors plus hand-written sequences
//                for load-use, multiply interlock, branch/PC interaction and
//                asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCWrPendingF, PCSrcW, BranchTakenD, MulOpE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE;

  int checks;
  int failures;

  hazard_unit #(
    .MUL_CYCLES (3),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .WA3M         (WA3M),
    .WA3W         (WA3W),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCWrPendingF (PCWrPendingF),
    .PCSrcW       (PCSrcW),
    .BranchTakenD (BranchTakenD),
    .MulOpE       (MulOpE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .MulBusyE     (MulBusyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-output packing: {FA[1:0], FB[1:0], SF, SD, SE, FD, FE, FM, BUSY}
  typedef struct packed {
    logic [3:0]  ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic        rwe, rwm, rww, m2r, pcwp, pcsrc, btd;
    logic [10:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [10:0] outs();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE,
            FlushD, FlushE, FlushM, MulBusyE};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got FA/FB/SF/SD/SE/FD/FE/FM/BUSY=%b required %b", name, act, exp);
    end
  endtask

  task automatic add_vec(
    input logic [3:0] ra1d, input logic [3:0] ra2d, input logic [3:0] ra1e,
    input logic [3:0] ra2e, input logic [3:0] wa3e, input logic [3:0] wa3m,
    input logic [3:0] wa3w, input logic rwe, input logic rwm, input logic rww,
    input logic m2r, input logic pcwp, input logic pcsrc, input logic btd,
    input logic [10:0] exp
  );
    vec_t v;
    v = {ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
         rwe, rwm, rww, m2r, pcwp, pcsrc, btd, exp};
    vq.push_back(v);
  endtask

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCWrPendingF = 1'b0; PCSrcW = 1'b0; BranchTakenD = 1'b0; MulOpE = 1'b0;
  endtask

  // Advance to the middle of the next cycle (inputs change at negedge)
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    reset = 1'b1;

    //        ra1d ra2d ra1e ra2e wa3e wa3m wa3w rwe rwm rww m2r pcw pcs btd  FA FB SF SD SE FD FE FM BUSY
    add_vec(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0,0,0,0,0,0,0, 11'b00_00_000_000_0);
    add_vec(4'd0, 4'd0, 4'd1, 4'd3, 4'd0, 4'd1, 4'd1, 0,1,1,0,0,0,0, 11'b10_00_000_000_0);
    add_vec(4'd0, 4'd0, 4'd1, 4'd3, 4'd0, 4'd1, 4'd1, 0,0,1,0,0,0,0, 11'b01_00_000_000_0);
    add_vec(4'd0, 4'd0, 4'd15,4'd15,4'd0, 4'd15,4'd15,0,1,1,0,0,0,0, 11'b00_00_000_000_0);
    add_vec(4'd0, 4'd0, 4'd6, 4'd5, 4'd0, 4'd5, 4'd5, 0,1,1,0,0,0,0, 11'b00_10_000_000_0);
    add_vec(4'd0, 4'd0, 4'd8, 4'd7, 4'd0, 4'd8, 4'd7, 0,1,1,0,0,0,0, 11'b10_01_000_000_0);
    add_vec(4'd0, 4'd2, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 1,0,0,1,0,0,0, 11'b00_00_110_010_0);
    add_vec(4'd4, 4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 1,0,0,1,0,0,0, 11'b00_00_110_010_0);
    add_vec(4'd3, 4'd5, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 1,0,0,1,0,0,0, 11'b00_00_000_000_0);
    add_vec(4'd2, 4'd2, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 0,0,0,1,0,0,0, 11'b00_00_000_000_0);
    add_vec(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0,0,0,0,1,0,0, 11'b00_00_100_100_0);
    add_vec(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0,0,0,0,0,1,0, 11'b00_00_000_110_0);
    add_vec(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0,0,0,0,0,0,1, 11'b00_00_000_110_0);
    add_vec(4'd0, 4'd2, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 1,0,0,1,0,0,1, 11'b00_00_110_010_0);

    #1;
    check("reset_state", 11'b00_00_000_000_0);
    next_cycle();
    reset = 1'b0;

    // ---------------- combinational vector table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      next_cycle();
      RA1D = vq[i].ra1d; RA2D = vq[i].ra2d; RA1E = vq[i].ra1e; RA2E = vq[i].ra2e;
      WA3E = vq[i].wa3e; WA3M = vq[i].wa3m; WA3W = vq[i].wa3w;
      RegWriteE = vq[i].rwe; RegWriteM = vq[i].rwm; RegWriteW = vq[i].rww;
      MemtoRegE = vq[i].m2r; PCWrPendingF = vq[i].pcwp; PCSrcW = vq[i].pcsrc;
      BranchTakenD = vq[i].btd; MulOpE = 1'b0;
      #1;
      check($sformatf("vec%0d", i), vq[i].exp);
    end

    // ---------------- load-use: one stall cycle, then bubble in E ----------
    next_cycle();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd9;
    #1; check("ldr_stall", 11'b00_00_110_010_0);
    next_cycle();
    MemtoRegE = 1'b0; RegWriteE = 1'b0;
    #1; check("ldr_release", 11'b00_00_000_000_0);

    // ---------------- multiply, 3 cycles in E ----------------
    next_cycle();
    clear_inputs();
    MulOpE = 1'b1;
    #1; check("mul_c1", 11'b00_00_111_001_0);
    next_cycle();
    #1; check("mul_c2", 11'b00_00_111_001_1);
    next_cycle();
    #1; check("mul_c3", 11'b00_00_000_000_1);
    next_cycle();
    MulOpE = 1'b0;
    #1; check("mul_done", 11'b00_00_000_000_0);

    // ---------------- multiply with a taken branch in D ----------------
    next_cycle();
    MulOpE = 1'b1; BranchTakenD = 1'b1;
    #1; check("mulbr_c1", 11'b00_00_111_001_0);
    next_cycle();
    #1; check("mulbr_c2", 11'b00_00_111_001_1);
    next_cycle();
    #1; check("mulbr_c3", 11'b00_00_000_110_1);
    next_cycle();
    clear_inputs();
    #1; check("mulbr_done", 11'b00_00_000_000_0);

    // ---------------- PC write kills a multiply in BUSY ----------------
    next_cycle();
    MulOpE = 1'b1;
    #1; check("kill_c1", 11'b00_00_111_001_0);
    next_cycle();
    PCSrcW = 1'b1;
    #1; check("kill_c2", 11'b00_00_000_110_1);
    next_cycle();
    PCSrcW = 1'b0; MulOpE = 1'b0;
    #1; check("kill_idle", 11'b00_00_000_000_0);

    // ---------------- asynchronous reset mid-BUSY ----------------
    next_cycle();
    MulOpE = 1'b1;
    #1; check("rst_c1", 11'b00_00_111_001_0);
    next_cycle();
    #1; check("rst_c2_busy", 11'b00_00_111_001_1);
    #1;
    reset = 1'b1;
    #1; check("rst_async", 11'b00_00_000_000_0);
    next_cycle();
    #1; check("rst_held", 11'b00_00_000_000_0);
    reset = 1'b0;
    #1; check("rst_fresh_c1", 11'b00_00_111_001_0);
    next_cycle();
    #1; check("rst_fresh_c2", 11'b00_00_111_001_1);
    next_cycle();
    #1; check("rst_fresh_c3", 11'b00_00_000_000_1);
    next_cycle();
    MulOpE = 1'b0;
    #1; check("rst_fresh_done", 11'b00_00_000_000_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
